// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - op and FSM state codes shared by the multiply/divide unit
package alu_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/alu_muldiv_negate.sv
// rtl/alu_muldiv_negate.sv - conditional two's-complement negate (dout = neg ? -din : din)
module muldiv_negate #(
  parameter int W = 64
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative signed/unsigned multiply/divide, one bit per cycle
// Define ALU_MULDIV_FAST_PATH_EN to finish b==0 (any op) and a==0 (multiply) on the accept edge.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

  md_state_e          state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               in_signed;

  assign in_signed = md_is_signed(op);

  muldiv_negate #(.W(WIDTH)) u_mag_a (
    .neg (in_signed & a[WIDTH-1]),
    .din (a),
    .dout(mag_a)
  );

  muldiv_negate #(.W(WIDTH)) u_mag_b (
    .neg (in_signed & b[WIDTH-1]),
    .din (b),
    .dout(mag_b)
  );

  muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
    .neg (sign_a_q ^ sign_b_q),
    .din (acc_q),
    .dout(prod_fix)
  );

  muldiv_negate #(.W(WIDTH)) u_fix_quo (
    .neg (sign_a_q ^ sign_b_q),
    .din (acc_q[WIDTH-1:0]),
    .dout(quo_fix)
  );

  muldiv_negate #(.W(WIDTH)) u_fix_rem (
    .neg (sign_a_q),
    .din (acc_q[2*WIDTH-1:WIDTH]),
    .dout(rem_fix)
  );

  // MUL keeps {partial product, multiplier}; DIV keeps {remainder, dividend/quotient}.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_b_q};
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, mag_b_q};
  assign div_diff  = div_shift[WIDTH-1:0] - mag_b_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_raw_d  = a_raw_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    case (state_q)
      MD_IDLE: begin
        if (in_valid) begin
          op_d     = op;
          sign_a_d = in_signed & a[WIDTH-1];
          sign_b_d = in_signed & b[WIDTH-1];
          a_raw_d  = a;
          mag_b_d  = mag_b;
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          cnt_d    = CNT_W'(WIDTH);
          state_d  = MD_CALC;
`ifdef ALU_MULDIV_FAST_PATH_EN
          if ((b == '0) || ((a == '0) && !md_is_div(op))) begin
            cnt_d   = '0;
            hi_d    = md_is_div(op) ? a : '0;
            lo_d    = md_is_div(op) ? '1 : '0;
            dbz_d   = md_is_div(op);
            ovf_d   = 1'b0;
            state_d = MD_DONE;
          end
`endif
        end
      end
      MD_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (md_is_div(op_q)) begin
          if (div_ge) acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
          else        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        state_d = MD_DONE;
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
        if (!md_is_div(op_q)) begin
          {hi_d, lo_d} = prod_fix;
        end else if (mag_b_q == '0) begin
          hi_d  = a_raw_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d  = rem_fix;
          lo_d  = quo_fix;
          // MIN / -1 already wraps to MIN through the negate; only the flag is extra.
          ovf_d = (op_q == MD_DIV) && (a_raw_q == MIN_VAL) && sign_b_q && (mag_b_q == ONE_VAL);
        end
      end
      MD_DONE: begin
        if (out_ready) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_raw_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_raw_q  <= a_raw_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready    = (state_q == MD_IDLE);
  assign out_valid   = (state_q == MD_DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed table, randomized model check and handshake corners for alu_muldiv
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int W = 64;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MIN  = 64'h8000_0000_0000_0000;
`ifdef ALU_MULDIV_FAST_PATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] hi_o, lo_o;
  logic         dbz_o, ovf_o;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op_i),
    .a          (a_i),
    .b          (b_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .hi         (hi_o),
    .lo         (lo_o),
    .div_by_zero(dbz_o),
    .overflow   (ovf_o)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: plain wide arithmetic plus the two special divide rules.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo,
                                output logic dbz, output logic ovf);
    logic [2*W-1:0]  p;
    logic signed [W-1:0] sa, sb;
    sa = a; sb = b; dbz = 1'b0; ovf = 1'b0;
    hi = '0; lo = '0;
    if (op == MD_MULT) begin
      p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
      {hi, lo} = p;
    end else if (op == MD_MULTU) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      {hi, lo} = p;
    end else if (b == '0) begin
      lo = ONES; hi = a; dbz = 1'b1;
    end else if (op == MD_DIV && a == MIN && b == ONES) begin
      lo = a; hi = '0; ovf = 1'b1;
    end else if (op == MD_DIV) begin
      lo = sa / sb; hi = sa % sb;
    end else begin
      lo = a / b; hi = a % b;
    end
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit short_op;
    short_op = (b == '0) || ((a == '0) && !op[1]);
    return (FAST && short_op) ? 0 : W + 1;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] s;
    s = W'($urandom_range(1, 20));
    case ($urandom_range(0, 6))
      0: return '0;
      1: return s;
      2: return '0 - s;
      3: return MIN;
      4: return ONES;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // lat counts clock edges after the accept edge until out_valid is seen.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output logic dbz, output logic ovf, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    hi = hi_o; lo = lo_o; dbz = dbz_o; ovf = ovf_o;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, hi, lo;
    logic         dbz, ovf;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [W-1:0] hi, lo, ehi, elo, ra, rb;
    logic         dbz, ovf, edbz, eovf;
    logic [1:0]   rop;
    int           lat;

    vecs[0]  = '{MD_MULTU, 64'd3, 64'd5, 64'd0, 64'd15, 1'b0, 1'b0};
    vecs[1]  = '{MD_MULT, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0};
    vecs[2]  = '{MD_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
    vecs[3]  = '{MD_DIVU, 64'd7, 64'd2, 64'd1, 64'd3, 1'b0, 1'b0};
    vecs[4]  = '{MD_DIVU, 64'd7, 64'd0, 64'd7, ONES, 1'b1, 1'b0};
    vecs[5]  = '{MD_DIV, MIN, ONES, 64'd0, MIN, 1'b0, 1'b1};
    vecs[6]  = '{MD_MULTU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 1'b0};
    vecs[7]  = '{MD_DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0};
    vecs[8]  = '{MD_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, ONES, 64'd3, 1'b0, 1'b0};
    vecs[9]  = '{MD_MULT, MIN, ONES, 64'd0, MIN, 1'b0, 1'b0};
    vecs[10] = '{MD_DIV, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, ONES, 1'b1, 1'b0};
    vecs[11] = '{MD_MULTU, 64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset in_ready", W'(in_ready), 64'd1);
    chk("reset out_valid", W'(out_valid), 64'd0);
    chk("reset hi", hi_o, 64'd0);
    chk("reset lo", lo_o, 64'd0);
    chk("reset flags", W'({dbz_o, ovf_o}), 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dbz, ovf, lat);
      chk($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      chk($sformatf("vec%0d lo", i), lo, vecs[i].lo);
      chk($sformatf("vec%0d div_by_zero", i), W'(dbz), W'(vecs[i].dbz));
      chk($sformatf("vec%0d overflow", i), W'(ovf), W'(vecs[i].ovf));
      chk($sformatf("vec%0d latency", i), W'(lat), W'(exp_lat(vecs[i].op, vecs[i].a, vecs[i].b)));
    end

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = pick_operand();
      rb = pick_operand();
      model(rop, ra, rb, ehi, elo, edbz, eovf);
      run_op(rop, ra, rb, hi, lo, dbz, ovf, lat);
      chk($sformatf("rnd%0d op%0d a=%h b=%h hi", i, rop, ra, rb), hi, ehi);
      chk($sformatf("rnd%0d op%0d a=%h b=%h lo", i, rop, ra, rb), lo, elo);
      chk($sformatf("rnd%0d flags", i), W'({dbz, ovf}), W'({edbz, eovf}));
      chk($sformatf("rnd%0d latency", i), W'(lat), W'(exp_lat(rop, ra, rb)));
    end

    // Reset during CALC after a result has left hi/lo non-zero.
    run_op(MD_DIVU, 64'd100, 64'd7, hi, lo, dbz, ovf, lat);
    chk("pre-reset lo", lo, 64'd14);
    @(posedge clk); #1;
    in_valid = 1'b1; op_i = MD_MULTU; a_i = 64'd9; b_i = 64'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("midreset out_valid", W'(out_valid), 64'd0);
    chk("midreset in_ready", W'(in_ready), 64'd1);
    chk("midreset hi", hi_o, 64'd0);
    chk("midreset lo", lo_o, 64'd0);
    repeat (70) @(posedge clk);
    #1 chk("midreset op discarded", W'(out_valid), 64'd0);
    run_op(MD_MULTU, 64'd9, 64'd11, hi, lo, dbz, ovf, lat);
    chk("post-reset lo", lo, 64'd99);
    chk("post-reset latency", W'(lat), W'(W + 1));

    // Back-pressure: result held, new operands ignored, release returns to IDLE.
    @(posedge clk); #1;
    out_ready = 1'b0;
    run_op(MD_DIVU, 64'd100, 64'd7, hi, lo, dbz, ovf, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op_i = MD_MULTU; a_i = {$urandom, $urandom}; b_i = 64'd3;
      @(posedge clk); #1;
      chk($sformatf("hold%0d out_valid", i), W'(out_valid), 64'd1);
      chk($sformatf("hold%0d in_ready", i), W'(in_ready), 64'd0);
      chk($sformatf("hold%0d hi", i), hi_o, 64'd2);
      chk($sformatf("hold%0d lo", i), lo_o, 64'd14);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release in_ready", W'(in_ready), 64'd1);
    chk("release out_valid", W'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("no re-accept in_ready", W'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
